// File: rtl/rv_pkg.sv
// Shared RV32M decode constants and the state encoding for the EX-stage
// multiply/divide unit.
package rv_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_DONE
    } md_state_t;

endpackage

// File: rtl/md_div_core.sv
// Iterative unsigned restoring divider. A start pulse loads the operands;
// each following clock resolves DIV_STEPS_PER_CYCLE quotient bits. During
// the last iteration cycle 'done' is high and quotient/remainder present the
// final values combinationally so the caller can register them on that edge.
module md_div_core
    import rv_pkg::*;
#(
    parameter int DIV_STEPS_PER_CYCLE = 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            done,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);

    localparam int ITERS = XLEN / DIV_STEPS_PER_CYCLE;

    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic [5:0]      cnt_q, cnt_d;

    logic [XLEN-1:0] rem_n;
    logic [XLEN-1:0] quo_n;
    logic [XLEN:0]   shifted;

    // Shift-compare-subtract steps applied to the current partial remainder.
    always_comb begin
        rem_n   = rem_q;
        quo_n   = quo_q;
        shifted = '0;
        for (int i = 0; i < DIV_STEPS_PER_CYCLE; i++) begin
            shifted = {rem_n, quo_n[XLEN-1]};
            quo_n   = {quo_n[XLEN-2:0], 1'b0};
            if (shifted >= {1'b0, dvs_q}) begin
                shifted  = shifted - {1'b0, dvs_q};
                quo_n[0] = 1'b1;
            end
            rem_n = shifted[XLEN-1:0];
        end
    end

    assign done      = (cnt_q == 6'd1);
    assign quotient  = quo_n;
    assign remainder = rem_n;

    // Load on start, otherwise step while iterations remain.
    always_comb begin
        rem_d = rem_q;
        quo_d = quo_q;
        dvs_d = dvs_q;
        cnt_d = cnt_q;
        if (start) begin
            rem_d = '0;
            quo_d = dividend;
            dvs_d = divisor;
            cnt_d = 6'(ITERS);
        end else if (cnt_q != 6'd0) begin
            rem_d = rem_n;
            quo_d = quo_n;
            cnt_d = cnt_q - 6'd1;
        end
    end

    // Divider state registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
        end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            dvs_q <= dvs_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage RV32M unit: detects M ops, runs a one-cycle multiply or an
// iterative divide, stalls the front end meanwhile and pulses md_valid with
// the result. Divide sign handling lives here; md_div_core is unsigned.
module ex_muldiv_unit
    import rv_pkg::*;
#(
    parameter int CORE                = 0,
    parameter int DIV_STEPS_PER_CYCLE = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [6:0]       ex_opcode,
    input  logic [2:0]       ex_funct3,
    input  logic [6:0]       ex_funct7,
    input  logic [XLEN-1:0]  ex_rs1_data,
    input  logic [XLEN-1:0]  ex_rs2_data,
    input  logic [4:0]       ex_rd,
    input  logic             ex_flush,
    output logic             md_stall,
    output logic             md_valid,
    output logic [XLEN-1:0]  md_result,
    output logic [4:0]       md_rd
);

    // The core id only labels the instance; an impossible id elaborates nothing.
    if (CORE < 0) begin : g_core_id_unused
    end

    md_state_t       state_q, state_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [4:0]      rd_q, rd_d;
    logic            neg_quo_q, neg_quo_d;
    logic            neg_rem_q, neg_rem_d;
    logic [XLEN-1:0] md_result_q, md_result_d;
    logic [4:0]      md_rd_q, md_rd_d;

    logic            m_op;
    logic            signed_div, a_neg, b_neg, div_by_zero, div_ovf;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            div_start, div_done;
    logic [XLEN-1:0] div_quo, div_rem;
    logic            mul_sa, mul_sb;
    logic [63:0]     a_wide, b_wide, prod;
    logic [XLEN-1:0] mul_word, quo_fix, rem_fix;

    assign m_op = (ex_opcode == OPCODE_OP) && (ex_funct7 == FUNCT7_MULDIV);

    assign signed_div  = ~ex_funct3[0];
    assign a_neg       = signed_div & ex_rs1_data[XLEN-1];
    assign b_neg       = signed_div & ex_rs2_data[XLEN-1];
    assign a_mag       = a_neg ? (~ex_rs1_data + 32'd1) : ex_rs1_data;
    assign b_mag       = b_neg ? (~ex_rs2_data + 32'd1) : ex_rs2_data;
    assign div_by_zero = (ex_rs2_data == 32'd0);
    assign div_ovf     = signed_div && (ex_rs1_data == 32'h8000_0000) &&
                         (ex_rs2_data == 32'hFFFF_FFFF);

    // 33-bit sign/zero extension carried into a 64-bit product.
    assign mul_sa   = (funct3_q == F3_MULH || funct3_q == F3_MULHSU) & a_q[XLEN-1];
    assign mul_sb   = (funct3_q == F3_MULH) & b_q[XLEN-1];
    assign a_wide   = {{32{mul_sa}}, a_q};
    assign b_wide   = {{32{mul_sb}}, b_q};
    assign prod     = a_wide * b_wide;
    assign mul_word = (funct3_q == F3_MUL) ? prod[31:0] : prod[63:32];

    assign quo_fix = neg_quo_q ? (~div_quo + 32'd1) : div_quo;
    assign rem_fix = neg_rem_q ? (~div_rem + 32'd1) : div_rem;

    md_div_core #(
        .DIV_STEPS_PER_CYCLE(DIV_STEPS_PER_CYCLE)
    ) u_div (
        .clock    (clock),
        .reset    (reset),
        .start    (div_start),
        .dividend (a_mag),
        .divisor  (b_mag),
        .done     (div_done),
        .quotient (div_quo),
        .remainder(div_rem)
    );

    // Next-state, operand capture, result selection, stall and valid.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        funct3_d    = funct3_q;
        rd_d        = rd_q;
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;
        md_result_d = md_result_q;
        md_rd_d     = md_rd_q;
        div_start   = 1'b0;
        md_stall    = 1'b0;
        md_valid    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (m_op && !ex_flush) begin
                    md_stall = 1'b1;
                    a_d      = ex_rs1_data;
                    b_d      = ex_rs2_data;
                    funct3_d = ex_funct3;
                    rd_d     = ex_rd;
                    if (!ex_funct3[2]) begin
                        state_d = ST_MUL;
                    end else if (div_by_zero) begin
                        md_result_d = ex_funct3[1] ? ex_rs1_data : 32'hFFFF_FFFF;
                        md_rd_d     = ex_rd;
                        state_d     = ST_DONE;
                    end else if (div_ovf) begin
                        md_result_d = ex_funct3[1] ? 32'd0 : 32'h8000_0000;
                        md_rd_d     = ex_rd;
                        state_d     = ST_DONE;
                    end else begin
                        div_start = 1'b1;
                        neg_quo_d = a_neg ^ b_neg;
                        neg_rem_d = a_neg;
                        state_d   = ST_DIV;
                    end
                end
            end
            ST_MUL: begin
                md_stall    = 1'b1;
                md_result_d = mul_word;
                md_rd_d     = rd_q;
                state_d     = ST_DONE;
            end
            ST_DIV: begin
                md_stall = 1'b1;
                if (div_done) begin
                    md_result_d = funct3_q[1] ? rem_fix : quo_fix;
                    md_rd_d     = rd_q;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: begin
                md_valid = 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (ex_flush) begin
            state_d     = ST_IDLE;
            md_result_d = md_result_q;
            md_rd_d     = md_rd_q;
            md_stall    = 1'b0;
            md_valid    = 1'b0;
        end
        if (reset) begin
            md_stall = 1'b0;
        end
    end

    // State, captured operands and the held result.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            funct3_q    <= '0;
            rd_q        <= '0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            md_result_q <= '0;
            md_rd_q     <= '0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            funct3_q    <= funct3_d;
            rd_q        <= rd_d;
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
            md_result_q <= md_result_d;
            md_rd_q     <= md_rd_d;
        end
    end

    assign md_result = md_result_q;
    assign md_rd     = md_rd_q;

endmodule
